// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the sequential radix-4 Booth multiplier.
//   state_t       : controller states (IDLE, BUSY, DONE)
//   booth_digit_t : decoded Booth digit {neg, one, two}
//   ndig(n)       : number of radix-4 digits needed for an n-bit operand
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Selects 0, +/-1 or +/-2 times the multiplicand.
    // Zero is one=0 and two=0; neg is never set for zero.
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    function automatic int ndig(input int n);
        return (n + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_enc.sv
// booth_enc: radix-4 Booth digit encoder.
//   win   in  3  multiplier window {b[2i+1], b[2i], b[2i-1]}
//   digit out    decoded digit {neg, one, two}
module booth_enc
    import booth_pkg::*;
(
    input  logic [2:0]   win,
    output booth_digit_t digit
);

    always_comb begin
        digit = '0;
        case (win)
            3'b001, 3'b010: digit.one = 1'b1;
            3'b011:         digit.two = 1'b1;
            3'b100:         begin digit.two = 1'b1; digit.neg = 1'b1; end
            3'b101, 3'b110: begin digit.one = 1'b1; digit.neg = 1'b1; end
            default:        digit = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier, one digit per clock.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (A, B, is_signed sampled on accept)
//   out_valid/out_ready  result handshake; result held while stalled
//   result               2N-bit product (two's complement when signed)
// Optional: define BOOTH_EARLY_TERM_EN to finish as soon as every remaining
// Booth digit is zero (latency = digits actually needed, minimum 1).
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int N = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           is_signed,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result
);

    localparam int NDIG = ndig(N);
    localparam int EW   = N + 2;
    localparam int AW   = 2 * N + 4;
    localparam int CW   = $clog2(NDIG) + 1;

    state_t         state;
    // Multiplicand pre-shifted by 2i, so no variable shifter is needed.
    logic [AW-1:0]  a_sh;
    // Multiplier shifted right by 2 each digit; bit 0 is b[2i-1].
    logic [EW:0]    b_sh;
    logic [AW-1:0]  acc;
    logic [CW-1:0]  cnt;

    logic [EW-1:0]  a_ext;
    logic [EW-1:0]  b_ext;
    booth_digit_t   digit;
    logic [AW-1:0]  mag;
    logic [AW-1:0]  addend;
    logic [AW-1:0]  acc_next;
    logic [EW:0]    b_next;
    logic           finish;

    booth_enc u_enc (
        .win   (b_sh[2:0]),
        .digit (digit)
    );

    always_comb begin
        a_ext    = is_signed ? {{2{A[N-1]}}, A} : {2'b00, A};
        b_ext    = is_signed ? {{2{B[N-1]}}, B} : {2'b00, B};
        mag      = digit.two ? {a_sh[AW-2:0], 1'b0} : (digit.one ? a_sh : '0);
        addend   = digit.neg ? (~mag + AW'(1)) : mag;
        acc_next = acc + addend;
        // Arithmetic shift keeps the upper bits equal to the extended sign.
        b_next   = {{2{b_sh[EW]}}, b_sh[EW:2]};
`ifdef BOOTH_EARLY_TERM_EN
        // Remaining windows of identical bits all decode to zero.
        finish   = (cnt == CW'(NDIG - 1)) || (&b_next) || !(|b_next);
`else
        finish   = (cnt == CW'(NDIG - 1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= {{(AW - EW){a_ext[EW-1]}}, a_ext};
                        b_sh     <= {b_ext, 1'b0};
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= acc_next;
                    a_sh <= {a_sh[AW-3:0], 2'b00};
                    b_sh <= b_next;
                    cnt  <= cnt + CW'(1);
                    if (finish) begin
                        result    <= acc_next[2*N-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and random checks of booth_mul_seq (N=10)
// against a scoreboard of reference products and expected latencies.
module tb_booth_mul_seq;

    localparam int N    = 10;
    localparam int NDIG = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           is_signed;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] result;

    int errors = 0;
    int checks = 0;

    logic [2*N-1:0] exp_q[$];
    int             lat_q[$];

    always #5 clk = ~clk;

    booth_mul_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic s);
        longint ea, eb, p;
        ea = longint'(a);
        eb = longint'(b);
        if (s && a[N-1]) ea = ea - (longint'(1) << N);
        if (s && b[N-1]) eb = eb - (longint'(1) << N);
        p = ea * eb;
        return p[2*N-1:0];
    endfunction

    // Smallest digit count after which every remaining multiplier bit matches the sign fill.
    function automatic int need_dig(input logic [N-1:0] b, input logic s);
        logic [N+2:0] v;
        logic         ok;
        v = {(s ? {2{b[N-1]}} : 2'b00), b, 1'b0};
        for (int k = 1; k <= NDIG; k++) begin
            ok = 1'b1;
            for (int j = 2 * k; j <= N + 2; j++)
                if (v[j] != v[N+2]) ok = 1'b0;
            if (ok) return k;
        end
        return NDIG;
    endfunction

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns one ns after the accepting edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_send", longint'(in_ready), 1);
        A         = a;
        B         = b;
        is_signed = s;
        in_valid  = 1'b1;
        exp_q.push_back(model(a, b, s));
`ifdef BOOTH_EARLY_TERM_EN
        lat_q.push_back(need_dig(b, s));
`else
        lat_q.push_back(NDIG);
`endif
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        // Scramble operands in flight; the DUT must ignore them.
        A         = N'($urandom);
        B         = N'($urandom);
        is_signed = ~s;
        check("in_ready_busy", longint'(in_ready), 0);
    endtask

    // Waits for out_valid (bounded) and checks result and latency; ends at a negedge.
    task automatic get_result();
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("out_valid_rise", longint'(out_valid), 1);
        check("result", longint'(result), longint'(exp_q.pop_front()));
        check("latency", longint'(lat), longint'(lat_q.pop_front()));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_fall", longint'(out_valid), 0);
        check("in_ready_idle", longint'(in_ready), 1);
    endtask

    task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        send(a, b, s);
        get_result();
        consume();
    endtask

    initial begin
        logic [2*N-1:0] held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        A         = '0;
        B         = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_result", longint'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // out_ready without a pending result does nothing.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stray_ready_out_valid", longint'(out_valid), 0);
        check("stray_ready_in_ready", longint'(in_ready), 1);

        run(10'd1, 10'd1, 1'b1);
        run(10'h200, 10'h200, 1'b1);
        run(10'd1, 10'h3FF, 1'b1);
        run(10'h3FF, 10'h3FF, 1'b0);
        run(10'd0, 10'h3FF, 1'b0);
        run(10'd7, 10'd1, 1'b1);
        run(10'h1FF, 10'h200, 1'b1);
        run(10'h3FF, 10'h200, 1'b0);

        // Backpressure: hold out_ready low for 5 cycles in DONE.
        send(10'd5, 10'h3FD, 1'b1);
        get_result();
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result_hold", longint'(result), longint'(held));
            check("bp_out_valid_hold", longint'(out_valid), 1);
            check("bp_in_ready_low", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_out_valid", longint'(out_valid), 0);
        check("bp_release_in_ready", longint'(in_ready), 1);
        send(10'd12, 10'd13, 1'b0);
        get_result();
        consume();

        // Reset during BUSY digit 3 aborts the operation.
        send(10'd100, 10'd200, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_result", longint'(result), 0);
        check("abort_in_ready", longint'(in_ready), 1);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(10'd3, 10'd5, 1'b1);

        for (int i = 0; i < 100; i++)
            run(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));

        check("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
